// File: rtl/uart_fifo_fwft_prog.sv
// -----------------------------------------------------------------------------
// uart_fifo_fwft_prog
//   First-word-fall-through FIFO for the UART TX/RX data paths. Storage is a
//   plain register array of exactly 2**FIFO_AW entries; the head word is read
//   combinationally, so it is visible as soon as o_valid rises.
//   Extras: runtime almost-full/almost-empty thresholds, synchronous flush,
//   per-entry even parity with a fault-injection hook, sticky overflow and
//   underflow flags, and a high-water-mark of occupancy.
//
// Ports
//   i_clk, i_rst         clock; synchronous active-high reset
//   i_wr_req, i_data_in  push request and data
//   i_rd_req             pop the head word shown on o_data_out
//   i_flush              discard all contents on the next edge
//   i_afull_thr          almost-full threshold  (o_almost_full  = used >= thr)
//   i_aempty_thr         almost-empty threshold (o_almost_empty = used <= thr)
//   i_par_inject         invert the parity stored with this cycle's write
//   i_err_clr            clear o_overflow, o_underflow, o_max_used
//   o_data_out, o_valid  head word (0 when empty) and its valid flag
//   o_empty, o_full      occupancy decodes
//   o_almost_full/empty  threshold decodes
//   o_used, o_free       occupancy and remaining space
//   o_max_used           peak occupancy since reset / last clear
//   o_overflow           sticky: write rejected while full
//   o_underflow          sticky: read attempted while empty
//   o_parity_error       head parity mismatch, qualified by o_valid
// -----------------------------------------------------------------------------
module uart_fifo_fwft_prog #(
    parameter int FIFO_AW            = 2,
    parameter int FIFO_DW            = 8,
    parameter int FIFO_PARITY_ENABLE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_req,
    input  logic [FIFO_DW-1:0] i_data_in,
    input  logic               i_rd_req,
    input  logic               i_flush,
    input  logic [FIFO_AW:0]   i_afull_thr,
    input  logic [FIFO_AW:0]   i_aempty_thr,
    input  logic               i_par_inject,
    input  logic               i_err_clr,
    output logic [FIFO_DW-1:0] o_data_out,
    output logic               o_valid,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic [FIFO_AW:0]   o_used,
    output logic [FIFO_AW:0]   o_free,
    output logic [FIFO_AW:0]   o_max_used,
    output logic               o_overflow,
    output logic               o_underflow,
    output logic               o_parity_error
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    logic [FIFO_DW-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   used;
    logic [FIFO_AW:0]   used_next;
    logic               rd_acc;
    logic               wr_acc;
    logic               wr_en;
    logic               ovf_set;
    logic               udf_set;

    // Status decodes come straight from the used counter.
    assign o_valid = (used != '0);
    assign o_empty = ~o_valid;
    assign o_full  = (used == DEPTH_C);
    assign o_used  = used;
    assign o_free  = DEPTH_C - used;

    // used never exceeds DEPTH, so a zero almost-full threshold and an
    // almost-empty threshold >= DEPTH saturate the flags without extra logic.
    assign o_almost_full  = (used >= i_afull_thr);
    assign o_almost_empty = (used <= i_aempty_thr);

    // A pop frees a slot in the same cycle, so a write to a full FIFO is
    // accepted when it coincides with a pop.
    assign rd_acc = i_rd_req & o_valid;
    assign wr_acc = i_wr_req & (~o_full | rd_acc);
    assign wr_en  = wr_acc & ~i_flush & ~i_rst;

    // Flush swallows the same-cycle requests, including their error reports.
    assign ovf_set = i_wr_req & o_full & ~rd_acc & ~i_flush;
    assign udf_set = i_rd_req & ~o_valid & ~i_flush;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        used_next = used;
        if (i_flush) begin
            used_next = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   used_next = used + (FIFO_AW + 1)'(1);
                2'b01:   used_next = used - (FIFO_AW + 1)'(1);
                default: used_next = used;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            used        <= '0;
            o_max_used  <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + FIFO_AW'(1);
                if (rd_acc) rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            used <= used_next;

            // Set wins over clear so an error in the clear cycle is not lost.
            if (ovf_set)        o_overflow <= 1'b1;
            else if (i_err_clr) o_overflow <= 1'b0;

            if (udf_set)        o_underflow <= 1'b1;
            else if (i_err_clr) o_underflow <= 1'b0;

            if (i_err_clr)                o_max_used <= used_next;
            else if (used_next > o_max_used) o_max_used <= used_next;
        end
    end

    // NOTE: the storage array has no reset; the pointers and counter define
    // which entries are meaningful, and an unreset array maps to plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= i_data_in;
    end

    // Empty FIFO presents zero rather than stale storage.
    assign o_data_out = o_valid ? mem[rd_ptr] : '0;

    generate
        if (FIFO_PARITY_ENABLE != 0) begin : g_par
            logic [DEPTH-1:0] par_mem;

            always_ff @(posedge i_clk) begin
                if (wr_en) par_mem[wr_ptr] <= (^i_data_in) ^ i_par_inject;
            end

            assign o_parity_error = o_valid & (par_mem[rd_ptr] != (^o_data_out));
        end else begin : g_nopar
            assign o_parity_error = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_uart_fifo_fwft_prog.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_fwft_prog
//   Directed bench for uart_fifo_fwft_prog (FIFO_AW=2, FIFO_DW=8). The driver
//   pushes each word it expects to be accepted into a scoreboard queue; a
//   monitor on the falling edge pops and compares whenever a pop is presented
//   (i_rd_req with o_valid). Status outputs are checked against hand-derived
//   constants one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_fifo_fwft_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req;
    logic [7:0] data_in;
    logic       rd_req;
    logic       flush;
    logic [2:0] afull_thr;
    logic [2:0] aempty_thr;
    logic       par_inject;
    logic       err_clr;
    logic [7:0] data_out;
    logic       valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] used;
    logic [2:0] free;
    logic [2:0] max_used;
    logic       overflow;
    logic       underflow;
    logic       parity_error;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_fifo_fwft_prog #(
        .FIFO_AW(2),
        .FIFO_DW(8),
        .FIFO_PARITY_ENABLE(1)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_req       (wr_req),
        .i_data_in      (data_in),
        .i_rd_req       (rd_req),
        .i_flush        (flush),
        .i_afull_thr    (afull_thr),
        .i_aempty_thr   (aempty_thr),
        .i_par_inject   (par_inject),
        .i_err_clr      (err_clr),
        .o_data_out     (data_out),
        .o_valid        (valid),
        .o_empty        (empty),
        .o_full         (full),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_used         (used),
        .o_free         (free),
        .o_max_used     (max_used),
        .o_overflow     (overflow),
        .o_underflow    (underflow),
        .o_parity_error (parity_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every presented pop must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rd_req && valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no pop (t=%0t)", data_out, $time);
            end else begin
                check("pop_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus; inputs return idle 1 unit after the edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic inj, input logic clr);
        wr_req = wr; data_in = d; rd_req = rd;
        flush = fl; par_inject = inj; err_clr = clr;
        @(posedge clk);
        #1;
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
        par_inject = 1'b0; err_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        exp_q.push_back(d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_req = 1'b0; data_in = 8'h00; rd_req = 1'b0;
        flush = 1'b0; par_inject = 1'b0; err_clr = 1'b0;
        afull_thr = 3'd3; aempty_thr = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_valid",  valid, 0);
        check("rst_empty",  empty, 1);
        check("rst_full",   full, 0);
        check("rst_free",   free, 4);
        check("rst_used",   used, 0);
        check("rst_data",   data_out, 8'h00);
        check("rst_par",    parity_error, 0);
        check("rst_max",    max_used, 0);
        check("rst_ovf",    overflow, 0);
        check("rst_udf",    underflow, 0);

        // 1: fill to full, drain in order
        push(8'h11);
        check("t1_aempty_1", almost_empty, 1);
        push(8'h22);
        check("t1_aempty_2", almost_empty, 0);
        check("t1_afull_2",  almost_full, 0);
        push(8'h33);
        check("t1_afull_3",  almost_full, 1);
        push(8'h44);
        check("t1_full",  full, 1);
        check("t1_used",  used, 4);
        check("t1_afull", almost_full, 1);
        check("t1_free",  free, 0);
        repeat (4) pop();
        check("t1_empty", empty, 1);
        check("t1_max",   max_used, 4);

        // Threshold saturation
        afull_thr = 3'd0; #1;
        check("thr_afull_zero", almost_full, 1);
        afull_thr = 3'd3; #1;

        // 2: fall-through latency and simultaneous push/pop
        push(8'hA5);
        check("t2_valid", valid, 1);
        check("t2_head",  data_out, 8'hA5);
        exp_q.push_back(8'h5A);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_head2", data_out, 8'h5A);
        check("t2_used",  used, 1);
        pop();

        // 3: overflow while full, then write-with-pop on full
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        aempty_thr = 3'd4; #1;
        check("thr_aempty_depth", almost_empty, 1);
        aempty_thr = 3'd1; #1;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_ovf",   overflow, 1);
        check("t3_used",  used, 4);
        check("t3_head",  data_out, 8'h01);
        exp_q.push_back(8'h99);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_used2", used, 4);
        check("t3_full2", full, 1);
        repeat (4) pop();
        check("t3_empty", empty, 1);
        check("t3_ovf_sticky", overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_ovf_clr", overflow, 0);
        check("t3_max_clr", max_used, 0);

        // 4: underflow and set-over-clear priority
        pop();
        check("t4_udf",   underflow, 1);
        check("t4_valid", valid, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_udf_clr", underflow, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_udf_prio", underflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // 5: flush with concurrent write, then pointer wrap
        push(8'hC1); push(8'hC2); push(8'hC3);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.delete();
        check("t5_used",  used, 0);
        check("t5_empty", empty, 1);
        check("t5_ovf",   overflow, 0);
        check("t5_max",   max_used, 3);
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 3; k++) push(8'((i << 4) | k));
            check("t5_wrap_used", used, 3);
            repeat (3) pop();
            check("t5_wrap_empty", empty, 1);
        end

        // 6: parity injection, then reset mid-fill
        exp_q.push_back(8'h3C);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        push(8'h3D);
        check("t6_head", data_out, 8'h3C);
        check("t6_par",  parity_error, 1);
        pop();
        check("t6_head2", data_out, 8'h3D);
        check("t6_par2",  parity_error, 0);
        pop();
        push(8'hE1); push(8'hE2);
        rst = 1'b1;
        step(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        rst = 1'b0;
        check("t6_rst_used",  used, 0);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_max",   max_used, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
